// File: rtl/floating_point_to_integer.sv
// Iterative float32 -> signed integer converter, truncating toward zero.
// Ports: clk_in/rst_in, floating_in+valid_in/ready_out in, integer_out+flags+valid_out/ready_in out.
module floating_point_to_integer #(
  parameter int DATA_WIDTH = 32,
  parameter int MENT_WIDTH = 23,
  parameter int EXPO_WIDTH = 8,
  parameter int INT_WIDTH  = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] floating_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic [INT_WIDTH-1:0]  integer_out,
  output logic                  overflow_out,
  output logic                  invalid_out,
  output logic                  inexact_out,
  output logic                  valid_out,
  input  logic                  ready_in
);

  localparam int EW = EXPO_WIDTH + 1;
  localparam int CW = $clog2(INT_WIDTH) + 1;

  typedef logic signed [EW-1:0] exp_t;

  localparam exp_t BIAS = EW'((1 << (EXPO_WIDTH - 1)) - 1);
  localparam exp_t EMAX = EW'(INT_WIDTH - 2);
  localparam exp_t ETOP = EW'(INT_WIDTH - 1);
  localparam exp_t EMNT = EW'(MENT_WIDTH);

  localparam logic [INT_WIDTH-1:0] MAXP = {1'b0, {(INT_WIDTH-1){1'b1}}};
  localparam logic [INT_WIDTH-1:0] MINN = {1'b1, {(INT_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, DECODE, SHIFT, SIGN, DONE
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] op_q, op_d;
  logic [INT_WIDTH-1:0]  mag_q, mag_d;
  logic [INT_WIDTH-1:0]  res_q, res_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  left_q, left_d;
  logic                  sticky_q, sticky_d;
  logic                  ovf_q, ovf_d;
  logic                  inv_q, inv_d;
  logic                  inx_q, inx_d;
  logic                  vld_q, vld_d;

  logic                  sgn;
  logic [EXPO_WIDTH-1:0] expo;
  logic [MENT_WIDTH-1:0] mant;
  exp_t                  e;
  exp_t                  dk;

  assign sgn  = op_q[DATA_WIDTH-1];
  assign expo = op_q[DATA_WIDTH-2 -: EXPO_WIDTH];
  assign mant = op_q[MENT_WIDTH-1:0];
  assign e    = exp_t'({1'b0, expo}) - BIAS;
  // distance from the binary point of {1,mant} to integer alignment
  assign dk   = (e >= EMNT) ? e - EMNT : EMNT - e;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mag_d    = mag_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    sticky_d = sticky_q;
    ovf_d    = ovf_q;
    inv_d    = inv_q;
    inx_d    = inx_q;
    vld_d    = vld_q;
    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          op_d    = floating_in;
          ovf_d   = 1'b0;
          inv_d   = 1'b0;
          inx_d   = 1'b0;
          state_d = DECODE;
        end
      end
      DECODE: begin
        sticky_d = 1'b0;
        state_d  = DONE;
        if (&expo) begin
          if (|mant) begin
            res_d = MAXP;
            inv_d = 1'b1;
          end else begin
            res_d = sgn ? MINN : MAXP;
            ovf_d = 1'b1;
          end
        end else if (expo == '0) begin
          res_d = '0;
          inx_d = |mant;
        end else if (e[EW-1]) begin
          res_d = '0;
          inx_d = 1'b1;
        end else if (e > EMAX) begin
          // -2^31 is the one representable value in this range
          if (sgn && e == ETOP && mant == '0) begin
            res_d = MINN;
          end else begin
            res_d = sgn ? MINN : MAXP;
            ovf_d = 1'b1;
          end
        end else begin
          mag_d   = INT_WIDTH'({1'b1, mant});
          left_d  = (e >= EMNT);
          cnt_d   = CW'(dk);
          state_d = (dk == '0) ? SIGN : SHIFT;
        end
      end
      SHIFT: begin
        if (left_q) begin
          mag_d = mag_q << 1;
        end else begin
          mag_d    = mag_q >> 1;
          sticky_d = sticky_q | mag_q[0];
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = SIGN;
      end
      SIGN: begin
        res_d   = sgn ? -mag_q : mag_q;
        inx_d   = sticky_q;
        state_d = DONE;
      end
      DONE: begin
        // first cycle publishes, then wait for the consumer
        if (!vld_q) begin
          vld_d = 1'b1;
        end else if (ready_in) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      op_q     <= '0;
      mag_q    <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
      inv_q    <= 1'b0;
      inx_q    <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mag_q    <= mag_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
      inv_q    <= inv_d;
      inx_q    <= inx_d;
      vld_q    <= vld_d;
    end
  end

  assign ready_out    = (state_q == IDLE);
  assign valid_out    = vld_q;
  assign integer_out  = res_q;
  assign overflow_out = ovf_q;
  assign invalid_out  = inv_q;
  assign inexact_out  = inx_q;

endmodule

// File: tb/tb_floating_point_to_integer.sv
// Bench for floating_point_to_integer.
// Directed vectors, arithmetic reference model, per-cycle output compare.
module tb_floating_point_to_integer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] floating_in;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] integer_out;
  logic        overflow_out;
  logic        invalid_out;
  logic        inexact_out;
  logic        valid_out;
  logic        ready_in;

  floating_point_to_integer dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .floating_in (floating_in),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .integer_out (integer_out),
    .overflow_out(overflow_out),
    .invalid_out (invalid_out),
    .inexact_out (inexact_out),
    .valid_out   (valid_out),
    .ready_in    (ready_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] f;
    logic [31:0] r;
    logic        ov;
    logic        iv;
    logic        ix;
    int          lat;
  } vec_t;

  int n_pass = 0;
  int n_chk  = 0;

  logic [31:0] e_r;
  logic        e_ov, e_iv, e_ix;
  int          e_lat;
  bit          armed = 1'b0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference: exact value by integer division, then range check.
  function automatic void model(input logic [31:0] f,
                                output logic [31:0] r,
                                output logic ov, output logic iv,
                                output logic ix, output int lat);
    logic        s;
    int          ex;
    int          e;
    int          sh;
    longint      m;
    longint      mag;
    logic [31:0] sat;
    s   = f[31];
    ex  = int'(f[30:23]);
    m   = longint'(f[22:0]);
    sat = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
    r = 0; ov = 0; iv = 0; ix = 0; lat = 2;
    if (ex == 255) begin
      if (m != 0) begin r = 32'h7FFF_FFFF; iv = 1; end
      else begin r = sat; ov = 1; end
    end else if (ex == 0) begin
      ix = (m != 0);
    end else begin
      e = ex - 127;
      if (e < 0) begin
        ix = 1;
      end else if (e >= 40) begin
        r = sat; ov = 1;
      end else begin
        mag = m + (longint'(1) << 23);
        if (e >= 23) begin
          mag = mag * (longint'(1) << (e - 23));
        end else begin
          sh  = 23 - e;
          ix  = (mag % (longint'(1) << sh)) != 0;
          mag = mag / (longint'(1) << sh);
        end
        if ((!s && mag > 64'sd2147483647) ||
            (s && mag > 64'sd2147483648)) begin
          r = sat; ov = 1; ix = 0;
        end else begin
          r = s ? 32'(-mag) : 32'(mag);
        end
        if (e <= 30) lat = ((e >= 23) ? e - 23 : 23 - e) + 3;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (armed && valid_out && !rst) begin
      check("out_int", integer_out, e_r);
      check("out_ovf", 32'(overflow_out), 32'(e_ov));
      check("out_inv", 32'(invalid_out), 32'(e_iv));
      check("out_inx", 32'(inexact_out), 32'(e_ix));
      check("busy_rdy", 32'(ready_out), 32'd0);
    end
  end

  task automatic conv(input vec_t v, input int hold, input bit pulse);
    int n;
    model(v.f, e_r, e_ov, e_iv, e_ix, e_lat);
    n = 0;
    while (!ready_out && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_rdy", 32'(ready_out), 32'd1);
    floating_in = v.f;
    valid_in    = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    armed = 1'b1;
    n = 0;
    while (!valid_out && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    check($sformatf("lat_%h", v.f), 32'(n), 32'(v.lat));
    check($sformatf("lit_%h", v.f), integer_out, v.r);
    for (int i = 0; i < hold; i++) begin
      if (pulse && i == 3) begin
        floating_in = 32'h4B00_0001;
        valid_in    = 1'b1;
      end
      if (pulse && i == 4) valid_in = 1'b0;
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    @(posedge clk);
    #1 ready_in = 1'b0;
    armed = 1'b0;
    check("vld_clr", 32'(valid_out), 32'd0);
    check("rdy_back", 32'(ready_out), 32'd1);
  endtask

  vec_t tbl[$];

  initial begin
    logic [31:0] pr;
    logic        pov, piv, pix;
    int          plat;
    vec_t        v123;

    tbl.push_back('{32'h3F80_0000, 32'h0000_0001, 0, 0, 0, 26});
    tbl.push_back('{32'hC020_0000, 32'hFFFF_FFFE, 0, 0, 1, 25});
    tbl.push_back('{32'h4B00_0001, 32'h0080_0001, 0, 0, 0, 3});
    tbl.push_back('{32'h4F00_0000, 32'h7FFF_FFFF, 1, 0, 0, 2});
    tbl.push_back('{32'hCF00_0000, 32'h8000_0000, 0, 0, 0, 2});
    tbl.push_back('{32'hFF80_0000, 32'h8000_0000, 1, 0, 0, 2});
    tbl.push_back('{32'h7F80_0000, 32'h7FFF_FFFF, 1, 0, 0, 2});
    tbl.push_back('{32'h7FC0_0000, 32'h7FFF_FFFF, 0, 1, 0, 2});
    tbl.push_back('{32'h0000_0001, 32'h0000_0000, 0, 0, 1, 2});
    tbl.push_back('{32'h8000_0000, 32'h0000_0000, 0, 0, 0, 2});
    tbl.push_back('{32'h3F00_0000, 32'h0000_0000, 0, 0, 1, 2});
    tbl.push_back('{32'h3FC0_0000, 32'h0000_0001, 0, 0, 1, 26});
    tbl.push_back('{32'h4EFF_FFFF, 32'h7FFF_FF80, 0, 0, 0, 10});
    tbl.push_back('{32'hCEFF_FFFF, 32'h8000_0080, 0, 0, 0, 10});
    tbl.push_back('{32'hCF00_0001, 32'h8000_0000, 1, 0, 0, 2});
    v123 = '{32'h42F6_0000, 32'h0000_007B, 0, 0, 0, 20};

    rst         = 1'b1;
    floating_in = '0;
    valid_in    = 1'b0;
    ready_in    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rdy", 32'(ready_out), 32'd1);
    check("rst_vld", 32'(valid_out), 32'd0);
    check("rst_int", integer_out, 32'd0);
    check("rst_flg", {29'd0, overflow_out, invalid_out, inexact_out}, 32'd0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      model(tbl[i].f, pr, pov, piv, pix, plat);
      check($sformatf("pin_r_%h", tbl[i].f), pr, tbl[i].r);
      check($sformatf("pin_f_%h", tbl[i].f), {29'd0, pov, piv, pix},
            {29'd0, tbl[i].ov, tbl[i].iv, tbl[i].ix});
      check($sformatf("pin_l_%h", tbl[i].f), 32'(plat), 32'(tbl[i].lat));
    end

    foreach (tbl[i]) conv(tbl[i], i % 3, 1'b0);

    // backpressure with an ignored operand pulse
    conv(tbl[1], 10, 1'b1);
    conv(tbl[3], 10, 1'b1);

    // reset in the middle of a long right shift
    @(negedge clk);
    floating_in = 32'h3F80_0000;
    valid_in    = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_vld", 32'(valid_out), 32'd0);
    check("mid_rst_rdy", 32'(ready_out), 32'd1);
    check("mid_rst_int", integer_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    conv(v123, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
